counter_sequence_checker: RTL and testbench

COUNTER_SEQUENCE_CHECKER -- requirements
Module: counter_sequence_checker

---
 rtl/counter_sequence_checker.sv | 85 ++++++++
 tb/tb_counter_sequence_checker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker: watches a 4-bit counter for correct +1 sequencing, locks after LOCK_CYCLES good steps, flags errors and wraps.
module counter_sequence_checker #(
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       q,
  input  logic             cnt_reset,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  state_t state_q, state_d;
  logic [3:0] prev_q, prev_d, match_q, match_d;
  logic locked_q, locked_d, err_q, err_d, wrap_q, wrap_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;
  logic match;
  logic [3:0] match_inc;
  assign match = q == prev_q + 4'd1;
  assign match_inc = match_q + 4'd1;
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    match_d = match_q;
    err_d = 1'b0;
    wrap_d = 1'b0;
    err_cnt_d = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (state_q == IDLE) begin
      if (!cnt_reset) begin
        prev_d = q;
        match_d = 4'd0;
        state_d = SYNC;
      end
    end else begin
      prev_d = q;
      // a counter held in reset is not checked; the next sample compares against prev+1
      if (!cnt_reset) begin
        if (state_q == SYNC) begin
          match_d = match ? match_inc : 4'd0;
          state_d = (match && match_inc == 4'(LOCK_CYCLES)) ? LOCKED : SYNC;
        end else if (match) begin
          wrap_d = prev_q == 4'hf;
          if (wrap_d && wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          match_d = 4'd0;
          state_d = SYNC;
        end
      end
    end
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q <= 4'd0;
      match_q <= 4'd0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      wrap_q <= 1'b0;
      err_cnt_q <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      match_q <= match_d;
      locked_q <= locked_d;
      err_q <= err_d;
      wrap_q <= wrap_d;
      err_cnt_q <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end
  assign locked = locked_q;
  assign err = err_q;
  assign wrap = wrap_q;
  assign err_count = err_cnt_q;
  assign wrap_count = wrap_cnt_q;
endmodule

// File: tb/tb_counter_sequence_checker.sv
// tb_counter_sequence_checker: directed checks of locking, errors, wraps, counter reset and saturation.
module tb_counter_sequence_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cnt_reset = 1'b0;
  logic [3:0] q = 4'd0;
  logic locked, err, wrap, locked2, err2, wrap2;
  logic [7:0] err_count, wrap_count;
  logic [1:0] err_count2, wrap_count2;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  counter_sequence_checker dut (
    .clk(clk), .reset(reset), .q(q), .cnt_reset(cnt_reset),
    .locked(locked), .err(err), .wrap(wrap),
    .err_count(err_count), .wrap_count(wrap_count)
  );
  counter_sequence_checker #(.LOCK_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .q(q), .cnt_reset(cnt_reset),
    .locked(locked2), .err(err2), .wrap(wrap2),
    .err_count(err_count2), .wrap_count(wrap_count2)
  );
  task automatic step(input logic [3:0] qv, input logic cr = 1'b0);
    q = qv;
    cnt_reset = cr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic l, input logic e, input logic w,
                         input logic [7:0] ec, input logic [7:0] wc);
    chk({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    chk({tag, ".wrap"}, {31'd0, wrap}, {31'd0, w});
    chk({tag, ".err_count"}, {24'd0, err_count}, {24'd0, ec});
    chk({tag, ".wrap_count"}, {24'd0, wrap_count}, {24'd0, wc});
  endtask
  initial begin
    logic [3:0] v;
    step(4'd5, 1'b1);
    step(4'd7);
    chk_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(4'(i));
      chk("ramp_unlocked", {31'd0, locked}, 0);
    end
    step(4'd4);
    chk_out("ramp_lock", 1, 0, 0, 0, 0);
    for (int i = 5; i < 16; i++) begin
      step(4'(i));
      chk_out("ramp_run", 1, 0, 0, 0, 0);
    end
    step(4'd0);
    chk_out("ramp_wrap", 1, 0, 1, 0, 1);
    step(4'd1);
    chk_out("ramp_after_wrap", 1, 0, 0, 0, 1);
    for (int i = 2; i < 7; i++) step(4'(i));
    step(4'd8);
    chk_out("skip_err", 0, 1, 0, 1, 1);
    step(4'd9);
    chk_out("skip_after", 0, 0, 0, 1, 1);
    step(4'd10);
    step(4'd11);
    chk("skip_still_sync", {31'd0, locked}, 0);
    step(4'd12);
    chk_out("skip_relock", 1, 0, 0, 1, 1);
    step(4'd13);
    step(4'd14);
    step(4'd15);
    step(4'd0);
    chk_out("second_wrap", 1, 0, 1, 1, 2);
    for (int i = 1; i < 8; i++) step(4'(i));
    chk_out("pre_stuck", 1, 0, 0, 1, 2);
    step(4'd7);
    chk_out("stuck_err", 0, 1, 0, 2, 2);
    for (int i = 8; i < 12; i++) step(4'(i));
    chk_out("stuck_relock", 1, 0, 0, 2, 2);
    for (int i = 0; i < 3; i++) begin
      step(4'd0, 1'b1);
      chk_out("cnt_reset_hold", 1, 0, 0, 2, 2);
    end
    step(4'd1);
    chk_out("cnt_reset_q1", 1, 0, 0, 2, 2);
    step(4'd2);
    chk_out("cnt_reset_q2", 1, 0, 0, 2, 2);
    reset = 1'b1;
    step(4'd3, 1'b1);
    chk_out("mid_reset", 0, 0, 0, 0, 0);
    chk("mid_reset.err_count2", {30'd0, err_count2}, 0);
    reset = 1'b0;
    step(4'd5);
    chk_out("restart_idle", 0, 0, 0, 0, 0);
    step(4'd6);
    step(4'd7);
    step(4'd8);
    chk("restart_sync", {31'd0, locked}, 0);
    step(4'd9);
    chk_out("restart_lock", 1, 0, 0, 0, 0);
    v = 4'd9;
    for (int k = 1; k <= 5; k++) begin
      step(v);
      chk("sat_err", {31'd0, err}, 1);
      chk("sat_err_count", {24'd0, err_count}, 32'(k));
      chk("sat_err_count2", {30'd0, err_count2}, (k > 3) ? 32'd3 : 32'(k));
      for (int i = 1; i <= 4; i++) step(v + 4'(i));
      chk("sat_relock", {31'd0, locked}, 1);
      chk("sat_relock2", {31'd0, locked2}, 1);
      v = v + 4'd4;
    end
    chk("sat_final2", {30'd0, err_count2}, 3);
    chk("sat_wrap_count2", {30'd0, wrap_count2}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
